// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, clamp function and e_hist tap indexing for the PID error stage.
package pid_pkg;
  localparam int PID_DATA_W = 10;
  localparam int PID_ERR_W  = 11;
  function automatic logic [32:0] clamp(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return v > hi ? {hi, 1'b1} : v < lo ? {lo, 1'b1} : {v, 1'b0};
  endfunction
  function automatic int tap_lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/err_sat.sv
// err_sat: signed error target - y with deadband and saturation to ERR_W.
module err_sat
  import pid_pkg::*;
#(
  parameter int DATA_W = PID_DATA_W,
  parameter int ERR_W  = PID_ERR_W
) (
  input  logic [DATA_W-1:0]       target,
  input  logic [DATA_W-1:0]       y,
  input  logic [DATA_W-1:0]       deadband,
  output logic signed [ERR_W-1:0] e,
  output logic                    sat
);
  logic signed [DATA_W:0] raw, dz;
  logic [DATA_W:0] mag;
  logic signed [31:0] cv;
  always_comb begin
    raw = $signed({1'b0, target}) - $signed({1'b0, y});
    mag = raw[DATA_W] ? -raw : raw;
    dz = mag <= {1'b0, deadband} ? '0 : raw;
    {cv, sat} = clamp(32'(dz), ERR_W);
    e = ERR_W'(cv);
  end
endmodule

// File: rtl/pid_error_pipe.sv
// pid_error_pipe: strobe-driven error history with first and second differences for an incremental PID.
module pid_error_pipe
  import pid_pkg::*;
#(
  parameter int DATA_W = PID_DATA_W,
  parameter int ERR_W  = PID_ERR_W,
  parameter int HIST   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic [DATA_W-1:0]       target,
  input  logic [DATA_W-1:0]       y,
  input  logic [DATA_W-1:0]       deadband,
  input  logic                    clear,
  output logic                    e_valid,
  output logic [HIST*ERR_W-1:0]   e_hist,
  output logic signed [ERR_W:0]   de1,
  output logic signed [ERR_W+1:0] dde,
  output logic                    sat_flag,
  output logic                    warm
);
  localparam int FW = $clog2(HIST + 1);
  logic signed [ERR_W-1:0] tap [HIST];
  logic signed [ERR_W-1:0] e;
  logic sat;
  logic [FW-1:0] fill, fill_nxt;
  err_sat #(.DATA_W(DATA_W), .ERR_W(ERR_W)) u_err_sat (
    .target(target), .y(y), .deadband(deadband), .e(e), .sat(sat)
  );
  assign fill_nxt = fill == FW'(HIST) ? fill : fill + FW'(1);
  always_ff @(posedge clk)
    if (rst || clear) begin
      for (int i = 0; i < HIST; i++) tap[i] <= '0;
      fill <= '0;
      warm <= 1'b0;
      sat_flag <= 1'b0;
      e_valid <= 1'b0;
    end else begin
      e_valid <= s_valid;
      if (s_valid) begin
        tap[0] <= e;
        for (int i = 1; i < HIST; i++) tap[i] <= tap[i-1];
        sat_flag <= sat;
        fill <= fill_nxt;
        warm <= fill_nxt == FW'(HIST);
      end
    end
  for (genvar i = 0; i < HIST; i++) begin : g_tap
    assign e_hist[tap_lo(i, ERR_W) +: ERR_W] = tap[i];
  end
  // widened before subtracting so the extreme tap combinations cannot wrap
  assign de1 = (ERR_W+1)'(tap[0]) - (ERR_W+1)'(tap[1]);
  assign dde = (ERR_W+2)'(tap[0]) - ((ERR_W+2)'(tap[1]) <<< 1) + (ERR_W+2)'(tap[2]);
endmodule

// File: tb/tb_pid_error_pipe.sv
// tb_pid_error_pipe: random and directed stimulus on an 11-bit/3-tap and an 8-bit/4-tap instance against an integer model.
module tb_pid_error_pipe;
  logic clk = 0, rst = 1, s_valid = 0, clear = 0;
  logic [9:0] target = 0, y = 0, deadband = 0;
  logic ev0, ev1, sat0, sat1, warm0, warm1;
  logic [32:0] eh0;
  logic [31:0] eh1;
  logic signed [11:0] de1_0;
  logic signed [12:0] dde_0;
  logic signed [8:0] de1_1;
  logic signed [9:0] dde_1;
  int checks = 0, failures = 0;
  bit run = 0;
  int h0 [3], h1 [4], f0, f1;
  bit m_ev, m_s0, m_s1;

  always #5 clk = ~clk;

  pid_error_pipe #(.DATA_W(10), .ERR_W(11), .HIST(3)) d0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .target(target), .y(y), .deadband(deadband),
    .clear(clear), .e_valid(ev0), .e_hist(eh0), .de1(de1_0), .dde(dde_0),
    .sat_flag(sat0), .warm(warm0)
  );
  pid_error_pipe #(.DATA_W(10), .ERR_W(8), .HIST(4)) d1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .target(target), .y(y), .deadband(deadband),
    .clear(clear), .e_valid(ev1), .e_hist(eh1), .de1(de1_1), .dde(dde_1),
    .sat_flag(sat1), .warm(warm1)
  );

  function automatic int dzf(int t, int yv, int db);
    int r = t - yv;
    return ((r < 0 ? -r : r) <= db) ? 0 : r;
  endfunction
  function automatic int clampf(int v, int w);
    int lim = 1 << (w - 1);
    return v > lim - 1 ? lim - 1 : v < -lim ? -lim : v;
  endfunction

  task automatic check(string n, int a, int x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", n, a, x, $time);
    end
  endtask

  always @(posedge clk)
    if (rst || clear) begin
      for (int i = 0; i < 3; i++) h0[i] <= 0;
      for (int i = 0; i < 4; i++) h1[i] <= 0;
      f0 <= 0; f1 <= 0; m_ev <= 0; m_s0 <= 0; m_s1 <= 0;
    end else begin
      m_ev <= s_valid;
      if (s_valid) begin
        h0[0] <= clampf(dzf(target, y, deadband), 11);
        for (int i = 1; i < 3; i++) h0[i] <= h0[i-1];
        h1[0] <= clampf(dzf(target, y, deadband), 8);
        for (int i = 1; i < 4; i++) h1[i] <= h1[i-1];
        m_s0 <= clampf(dzf(target, y, deadband), 11) != dzf(target, y, deadband);
        m_s1 <= clampf(dzf(target, y, deadband), 8) != dzf(target, y, deadband);
        f0 <= f0 < 3 ? f0 + 1 : 3;
        f1 <= f1 < 4 ? f1 + 1 : 4;
      end
    end

  always @(negedge clk)
    if (run) begin
      for (int i = 0; i < 3; i++) check("d0_tap", $signed(eh0[i*11 +: 11]), h0[i]);
      for (int i = 0; i < 4; i++) check("d1_tap", $signed(eh1[i*8 +: 8]), h1[i]);
      check("d0_de1", de1_0, h0[0] - h0[1]);
      check("d0_dde", dde_0, h0[0] - 2 * h0[1] + h0[2]);
      check("d1_de1", de1_1, h1[0] - h1[1]);
      check("d1_dde", dde_1, h1[0] - 2 * h1[1] + h1[2]);
      check("d0_ev", ev0, m_ev);
      check("d1_ev", ev1, m_ev);
      check("d0_sat", sat0, m_s0);
      check("d1_sat", sat1, m_s1);
      check("d0_warm", warm0, f0 == 3);
      check("d1_warm", warm1, f1 == 4);
    end

  task automatic step(bit sv, int t, int yv, int db, bit cl);
    s_valid = sv; target = 10'(t); y = 10'(yv); deadband = 10'(db); clear = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 0;
    run = 1;
    check("rst_tap0", $signed(eh0[10:0]), 0);
    check("rst_ev", ev0, 0);
    check("rst_warm", warm0, 0);
    check("rst_de1", de1_0, 0);
    check("rst_dde", dde_0, 0);
    step(1, 600, 500, 0, 0);
    check("one_tap0", $signed(eh0[10:0]), 100);
    check("one_ev", ev0, 1);
    step(0, 0, 0, 0, 0);
    check("one_ev_drop", ev0, 0);
    for (int i = 0; i < 5; i++) step(0, 77, 900, 3, 0);
    check("idle_tap0", $signed(eh0[10:0]), 100);
    step(0, 0, 0, 0, 1);
    step(1, 600, 500, 0, 0);
    step(1, 540, 500, 0, 0);
    check("seq_warm_early", warm0, 0);
    step(1, 480, 500, 0, 0);
    check("seq_tap0", $signed(eh0[10:0]), -20);
    check("seq_tap1", $signed(eh0[21:11]), 40);
    check("seq_tap2", $signed(eh0[32:22]), 100);
    check("seq_de1", de1_0, -60);
    check("seq_dde", dde_0, 0);
    check("seq_warm", warm0, 1);
    step(1, 1023, 0, 0, 0);
    check("big_tap0", $signed(eh0[10:0]), 1023);
    check("big_sat", sat0, 0);
    check("e8_tap0", $signed(eh1[7:0]), 127);
    check("e8_sat", sat1, 1);
    step(1, 0, 1023, 0, 0);
    check("neg_tap0", $signed(eh0[10:0]), -1023);
    check("e8_neg_tap0", $signed(eh1[7:0]), -128);
    check("e8_neg_sat", sat1, 1);
    step(1, 505, 500, 5, 0);
    check("db_in", $signed(eh0[10:0]), 0);
    step(1, 506, 500, 5, 0);
    check("db_pos", $signed(eh0[10:0]), 6);
    step(1, 494, 500, 5, 0);
    check("db_neg", $signed(eh0[10:0]), -6);
    step(1, 700, 500, 0, 1);
    check("clr_tap0", $signed(eh0[10:0]), 0);
    check("clr_ev", ev0, 0);
    check("clr_warm", warm0, 0);
    step(1, 700, 500, 0, 0);
    rst = 1;
    step(0, 0, 0, 0, 0);
    rst = 0;
    step(1, 550, 500, 0, 0);
    check("post_rst_tap0", $signed(eh0[10:0]), 50);
    check("post_rst_tap1", $signed(eh0[21:11]), 0);
    for (int i = 0; i < 600; i++) begin
      int t, yv, db;
      t = int'($urandom_range(0, 1023));
      yv = ($urandom % 3 == 0) ? int'($urandom_range(0, 1023)) :
           (t + int'($urandom_range(0, 60)) - 30 + 1024) % 1024;
      db = ($urandom % 4 == 0) ? int'($urandom_range(0, 40)) : 0;
      rst = ($urandom % 100) == 0;
      step(($urandom % 10) < 6, t, yv, db, ($urandom % 40) == 0);
    end
    rst = 0;
    step(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
